// File: rtl/mem_dma_if.sv
// Memory bus between the DMA engine and a memory responder.
// Follows the picorv32 native handshake: valid/addr/wstrb/wdata out, ready/rdata back.
interface mem_dma_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_instr,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_instr,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_dma.sv
// Word-by-word memory copy engine: read one word, write it, repeat, with a
// one-cycle idle gap after every completed bus transfer and a per-transfer timeout.
module mem_dma #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_done,
  mem_dma_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    GAP_W,
    WR,
    GAP_R,
    FIN
  } stateT;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  stateT       r_state;
  logic [31:0] r_srcPtr;
  logic [31:0] r_dstPtr;
  logic [15:0] r_len;
  logic [15:0] r_waitCnt;
  logic [15:0] r_wordsDone;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_memValid;
  logic [31:0] r_memAddr;
  logic [3:0]  r_memWstrb;
  logic [31:0] r_memWdata;

  logic [31:0] w_srcAligned;
  logic [31:0] w_dstAligned;

  assign w_srcAligned = src_addr & ~32'h3;
  assign w_dstAligned = dst_addr & ~32'h3;

  // Every bus output is a register, so addr/wstrb/wdata cannot move while valid is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_srcPtr    <= 32'h0;
      r_dstPtr    <= 32'h0;
      r_len       <= 16'h0;
      r_waitCnt   <= 16'h0;
      r_wordsDone <= 16'h0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_memValid  <= 1'b0;
      r_memAddr   <= 32'h0;
      r_memWstrb  <= 4'h0;
      r_memWdata  <= 32'h0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_srcPtr    <= w_srcAligned;
            r_dstPtr    <= w_dstAligned;
            r_len       <= len_words;
            r_wordsDone <= 16'h0;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            if (len_words != 16'h0) begin
              r_state    <= RD;
              r_memValid <= 1'b1;
              r_memAddr  <= w_srcAligned;
              r_memWstrb <= 4'h0;
              r_waitCnt  <= 16'h0;
            end else begin
              r_state <= FIN;
            end
          end
        end

        RD: begin
          if (bus.mem_ready) begin
            r_memWdata <= bus.mem_rdata;
            r_srcPtr   <= r_srcPtr + 32'd4;
            r_memValid <= 1'b0;
            r_state    <= GAP_W;
          end else if (r_waitCnt == TO_LAST) begin
            r_memValid <= 1'b0;
            r_memWstrb <= 4'h0;
            r_error    <= 1'b1;
            r_state    <= FIN;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end

        GAP_W: begin
          r_memValid <= 1'b1;
          r_memAddr  <= r_dstPtr;
          r_memWstrb <= 4'hF;
          r_waitCnt  <= 16'h0;
          r_state    <= WR;
        end

        WR: begin
          if (bus.mem_ready) begin
            r_dstPtr    <= r_dstPtr + 32'd4;
            r_wordsDone <= r_wordsDone + 16'd1;
            r_memValid  <= 1'b0;
            r_memWstrb  <= 4'h0;
            r_state     <= GAP_R;
          end else if (r_waitCnt == TO_LAST) begin
            r_memValid <= 1'b0;
            r_memWstrb <= 4'h0;
            r_error    <= 1'b1;
            r_state    <= FIN;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end

        GAP_R: begin
          if (r_wordsDone < r_len) begin
            r_memValid <= 1'b1;
            r_memAddr  <= r_srcPtr;
            r_memWstrb <= 4'h0;
            r_waitCnt  <= 16'h0;
            r_state    <= RD;
          end else begin
            r_state <= FIN;
          end
        end

        FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign words_done = r_wordsDone;

  assign bus.mem_valid = r_memValid;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wstrb = r_memWstrb;
  assign bus.mem_wdata = r_memWdata;

endmodule
